wb_ctrl: RTL and testbench
==========================

WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 Parameter LU_DEPTH, default 4: long-latency result FIFO depth, a power of 2, at least 2.
REQ-002 Parameter STALL_ON_FULL, default 1: when 1, a full FIFO asserts stall_req.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 pipe_we  in  1  pipeline writeback valid, never back-pressured.
REQ-006 pipe_waddr  in  5  pipeline destination register.
REQ-007 pipe_wdata  in  32  pipeline result.
REQ-008 iss_valid  in  1  long-latency op issued this cycle.
REQ-009 iss_waddr  in  5  destination of the issued long op.
REQ-010 lu_valid  in  1  long-latency unit result valid.
REQ-011 lu_ready  out  1  FIFO can accept a result; high when count < LU_DEPTH.
REQ-012 lu_waddr  in  5  long-latency result destination.
REQ-013 lu_wdata  in  32  long-latency result data.
REQ-014 rd_addr1, rd_addr2  in  5 each  decode-stage source registers.
REQ-015 rd_en1, rd_en2  in  1 each  source operand used.
REQ-016 stall_req  out  1  decode must hold this cycle.
REQ-017 we  out  1  register-file write enable.
REQ-018 waddr  out  5  register-file write address.
REQ-019 wdata  out  32  register-file write data.
REQ-020 busy  out  32  scoreboard; bit n means r(n) has a pending long-op write.
REQ-021 err  out  1  sticky protocol-violation flag.

Function
REQ-022 we, waddr and wdata are registered; a selected write appears on them exactly 1 cycle after selection.
REQ-023 A lu result is pushed when lu_valid && lu_ready; an entry is popped only when it is selected as the write.
REQ-024 Selection priority each cycle: a pipe write with pipe_we && pipe_waddr != 0 wins; otherwise the FIFO head is selected if the FIFO is not empty; otherwise we is driven 0 next cycle.
REQ-025 A pipe write to r0 is dropped and does not block the FIFO; a FIFO entry with waddr 0 is popped with we=0 and still clears no busy bit.
REQ-026 Push and pop in the same cycle are legal at any count below LU_DEPTH; count is unchanged.
REQ-027 busy[iss_waddr] sets on iss_valid with iss_waddr != 0; bit 0 is always 0.
REQ-028 busy[n] clears in the cycle the FIFO entry for r(n) is selected, i.e. together with the we/waddr update.
REQ-029 If a set and a clear of the same bit occur in the same cycle, the set wins.
REQ-030 iss_valid to a register whose busy bit is already set sets err; the bit stays set.
REQ-031 lu_valid with lu_waddr whose busy bit is clear sets err; the result is still written.
REQ-032 stall_req is combinational and asserts when (rd_en1 && busy[rd_addr1]) or (rd_en2 && busy[rd_addr2]), or when STALL_ON_FULL=1 and count == LU_DEPTH.
REQ-033 FIFO pointers wrap modulo LU_DEPTH; count is log2(LU_DEPTH)+1 bits wide.

Reset
REQ-034 While rst=1: we=0, waddr=0, wdata=0, busy=0, err=0, FIFO empty, lu_ready=1, stall_req driven by the hazard term only.
REQ-035 Reset asserted mid-operation discards all FIFO contents and pending busy bits immediately, without waiting for a clock edge.

Structure
REQ-036 The shared define package holds RegAddrBus/RegBus widths, WriteEnable, RstEnable and ZeroWord; no new package-level constants are added.
REQ-037 One sub-module, wb_fifo (a parameterized synchronous FIFO with async reset), holds the long-latency results; arbitration and the scoreboard live in wb_ctrl.

Verification
REQ-038 Scenario 1: pipe_we=1, r5 = 0x12345678 -> next cycle we=1, waddr=5, wdata=0x12345678.
REQ-039 Scenario 2: iss r7; 3 cycles later lu r7 = 0xDEADBEEF with pipe idle -> busy[7]=1 throughout; rd_en1 with rd_addr1=7 gives stall_req=1; the write appears and busy[7] clears in the same cycle.
REQ-040 Scenario 3: pipe_we held high for 6 cycles while 4 lu results arrive -> lu_ready drops at count 4; stall_req=1 at full; the FIFO drains in order once pipe_we falls.
REQ-041 Scenario 4: simultaneous lu push and FIFO pop at count 2 -> count stays 2 and ordering is preserved across pointer wrap.
REQ-042 Scenario 5: assert rst asynchronously with the FIFO at 3 entries and busy=0x00000880 -> all outputs are zero at once and lu_ready=1.
REQ-043 Scenario 6: iss r9 twice without a result, then lu r3 unissued -> err=1 and it stays set until reset.

Source files
------------

// File: rtl/wb_ctrl_pkg.sv
// Shared definitions for the writeback controller: register-file widths,
// control encodings and the long-latency result entry layout.
package wb_ctrl_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;

  localparam logic              WriteEnable = 1'b1;
  localparam logic              RstEnable   = 1'b1;
  localparam logic [RegBus-1:0] ZeroWord    = '0;

  typedef struct packed {
    logic [RegAddrBus-1:0] waddr;
    logic [RegBus-1:0]     wdata;
  } lu_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding long-latency results until the writeback port is free.
// The caller never pushes when full nor pops when empty.
module wb_fifo
  import wb_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  lu_entry_t i_data,
  input  logic      i_pop,
  output lu_entry_t o_data,
  output logic      o_empty,
  output logic      o_full
);

  localparam int AW = $clog2(DEPTH);

  lu_entry_t         r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  // NOTE: storage is deliberately not reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Power-of-2 depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/wb_ctrl.sv
// Writeback arbiter: merges the in-order pipeline write with queued long-latency
// results into one register-file write port, and tracks pending long-op targets.
module wb_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int LU_DEPTH      = 4,
  parameter bit STALL_ON_FULL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [RegAddrBus-1:0] pipe_waddr,
  input  logic [RegBus-1:0]     pipe_wdata,
  input  logic                  iss_valid,
  input  logic [RegAddrBus-1:0] iss_waddr,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [RegAddrBus-1:0] lu_waddr,
  input  logic [RegBus-1:0]     lu_wdata,
  input  logic [RegAddrBus-1:0] rd_addr1,
  input  logic [RegAddrBus-1:0] rd_addr2,
  input  logic                  rd_en1,
  input  logic                  rd_en2,
  output logic                  stall_req,
  output logic                  we,
  output logic [RegAddrBus-1:0] waddr,
  output logic [RegBus-1:0]     wdata,
  output logic [RegBus-1:0]     busy,
  output logic                  err
);

  lu_entry_t w_head;
  lu_entry_t w_lu_entry;
  logic      w_empty;
  logic      w_full;
  logic      w_pipe_sel;
  logic      w_pop;
  logic      w_push;

  logic [RegBus-1:0] w_busy_nxt;
  logic              w_err_nxt;

  logic                  r_we;
  logic [RegAddrBus-1:0] r_waddr;
  logic [RegBus-1:0]     r_wdata;
  logic [RegBus-1:0]     r_busy;
  logic                  r_err;

  // A pipe write to r0 is dropped outright so it never starves the FIFO.
  assign w_pipe_sel = pipe_we && (pipe_waddr != '0);
  assign w_pop      = !w_pipe_sel && !w_empty;
  assign w_push     = lu_valid && lu_ready;
  assign lu_ready   = !w_full;
  assign w_lu_entry = '{waddr: lu_waddr, wdata: lu_wdata};

  wb_fifo #(.DEPTH(LU_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_lu_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // NOTE: blocking assignments here; the set is applied after the clear so it wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop)     w_busy_nxt[w_head.waddr] = 1'b0;
    if (iss_valid) w_busy_nxt[iss_waddr]    = 1'b1;
    w_busy_nxt[0] = 1'b0;

    w_err_nxt = r_err;
    if (iss_valid && (iss_waddr != '0) && r_busy[iss_waddr]) w_err_nxt = 1'b1;
    if (lu_valid && !r_busy[lu_waddr])                       w_err_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_we    <= ~WriteEnable;
      r_waddr <= '0;
      r_wdata <= ZeroWord;
      r_busy  <= ZeroWord;
      r_err   <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_err  <= w_err_nxt;
      if (w_pipe_sel) begin
        r_we    <= WriteEnable;
        r_waddr <= pipe_waddr;
        r_wdata <= pipe_wdata;
      end else if (w_pop) begin
        r_we    <= (w_head.waddr != '0);
        r_waddr <= w_head.waddr;
        r_wdata <= w_head.wdata;
      end else begin
        r_we    <= ~WriteEnable;
      end
    end
  end

  assign stall_req = (rd_en1 && r_busy[rd_addr1]) || (rd_en2 && r_busy[rd_addr2]) ||
                     (STALL_ON_FULL && w_full);

  assign we    = r_we;
  assign waddr = r_waddr;
  assign wdata = r_wdata;
  assign busy  = r_busy;
  assign err   = r_err;

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl: table vectors, directed multi-cycle sequences
// and random traffic compared against a queue-based reference model.
module tb_wb_ctrl;
  import wb_ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        iss_valid;
  logic [4:0]  iss_waddr;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        rd_en1;
  logic        rd_en2;
  logic        stall_req;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] busy;
  logic        err;

  always #5 clk = ~clk;

  wb_ctrl #(.LU_DEPTH(DEPTH), .STALL_ON_FULL(1'b1)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .iss_valid(iss_valid), .iss_waddr(iss_waddr),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_en1(rd_en1), .rd_en2(rd_en2),
    .stall_req(stall_req), .we(we), .waddr(waddr), .wdata(wdata),
    .busy(busy), .err(err)
  );

  typedef struct packed {
    logic        pw; logic [4:0] pa; logic [31:0] pd;
    logic        iv; logic [4:0] ia;
    logic        lv; logic [4:0] la; logic [31:0] ld;
    logic        e1; logic [4:0] a1;
    logic        e2; logic [4:0] a2;
  } in_t;

  typedef struct packed {
    logic        pw; logic [4:0] pa; logic [31:0] pd;
    logic        ewe; logic [4:0] ea; logic [31:0] ed;
  } vec_t;

  typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;

  // Reference model: results queue, pending-register bitmap, sticky error, write port.
  ent_t        m_q[$];
  logic [31:0] m_busy;
  logic        m_err;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    pipe_we = v.pw;  pipe_waddr = v.pa; pipe_wdata = v.pd;
    iss_valid = v.iv; iss_waddr = v.ia;
    lu_valid = v.lv; lu_waddr = v.la; lu_wdata = v.ld;
    rd_en1 = v.e1; rd_addr1 = v.a1; rd_en2 = v.e2; rd_addr2 = v.a2;
  endtask

  // Called 1 time unit after a rising edge; applies one cycle of inputs.
  task automatic step(input in_t v, input string tag);
    bit   ready;
    bit   stall_e;
    ent_t e;
    drive(v);
    #1;
    ready   = (m_q.size() < DEPTH);
    stall_e = (v.e1 && m_busy[v.a1]) || (v.e2 && m_busy[v.a2]) || (m_q.size() == DEPTH);
    check({tag, ".lu_ready"}, 32'(lu_ready), 32'(ready));
    check({tag, ".stall"}, 32'(stall_req), 32'(stall_e));
    if (v.iv && v.ia != 0 && m_busy[v.ia]) m_err = 1'b1;
    if (v.lv && !m_busy[v.la])             m_err = 1'b1;
    if (v.pw && v.pa != 0) begin
      m_we = 1'b1; m_waddr = v.pa; m_wdata = v.pd;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_we = (e.a != 0); m_waddr = e.a; m_wdata = e.d;
      m_busy[e.a] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (v.lv && ready) begin
      e.a = v.la; e.d = v.ld;
      m_q.push_back(e);
    end
    if (v.iv) m_busy[v.ia] = 1'b1;
    m_busy[0] = 1'b0;
    @(posedge clk);
    #1;
    check({tag, ".we"}, 32'(we), 32'(m_we));
    check({tag, ".busy"}, busy, m_busy);
    check({tag, ".err"}, 32'(err), 32'(m_err));
    if (m_we) begin
      check({tag, ".waddr"}, 32'(waddr), 32'(m_waddr));
      check({tag, ".wdata"}, wdata, m_wdata);
    end
  endtask

  // Asserts reset between edges and checks outputs before any clock edge arrives.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, ".we"}, 32'(we), 32'd0);
    check({tag, ".waddr"}, 32'(waddr), 32'd0);
    check({tag, ".wdata"}, wdata, 32'd0);
    check({tag, ".busy"}, busy, 32'd0);
    check({tag, ".err"}, 32'(err), 32'd0);
    check({tag, ".lu_ready"}, 32'(lu_ready), 32'd1);
    check({tag, ".stall"}, 32'(stall_req), 32'd0);
    m_q.delete();
    m_busy = '0; m_err = 1'b0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    in_t        v;
    vec_t       tbl [5];
    logic [4:0] pend[$];
    bit         rdy;

    tbl[0] = '{1'b1, 5'd5,  32'h12345678, 1'b1, 5'd5,  32'h12345678};
    tbl[1] = '{1'b1, 5'd0,  32'hAAAA5555, 1'b0, 5'd0,  32'h00000000};
    tbl[2] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};
    tbl[3] = '{1'b0, 5'd9,  32'h00000001, 1'b0, 5'd0,  32'h00000000};
    tbl[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 5'd1,  32'h00000000};

    v = '0;
    drive(v);
    do_reset("rst0");

    // Plain pipeline writes, including the r0 drop.
    for (int i = 0; i < 5; i++) begin
      v = '0; v.pw = tbl[i].pw; v.pa = tbl[i].pa; v.pd = tbl[i].pd;
      step(v, "s1");
      check("s1.tbl_we", 32'(we), 32'(tbl[i].ewe));
      if (tbl[i].ewe) begin
        check("s1.tbl_waddr", 32'(waddr), 32'(tbl[i].ea));
        check("s1.tbl_wdata", wdata, tbl[i].ed);
      end
    end

    // Long op to r7: stall while pending, write and busy clear on the same edge.
    v = '0; v.iv = 1'b1; v.ia = 5'd7;
    step(v, "s2.iss");
    check("s2.busy7", 32'(busy[7]), 32'd1);
    for (int k = 0; k < 2; k++) begin
      v = '0; v.e1 = 1'b1; v.a1 = 5'd7;
      step(v, "s2.wait");
      check("s2.stall_hazard", 32'(stall_req), 32'd1);
    end
    v = '0; v.lv = 1'b1; v.la = 5'd7; v.ld = 32'hDEADBEEF; v.e1 = 1'b1; v.a1 = 5'd7;
    step(v, "s2.lu");
    check("s2.busy7_queued", 32'(busy[7]), 32'd1);
    check("s2.we_queued", 32'(we), 32'd0);
    v = '0; v.e1 = 1'b1; v.a1 = 5'd7;
    step(v, "s2.wr");
    check("s2.we", 32'(we), 32'd1);
    check("s2.waddr", 32'(waddr), 32'd7);
    check("s2.wdata", wdata, 32'hDEADBEEF);
    check("s2.busy7_clr", 32'(busy[7]), 32'd0);
    check("s2.stall_clr", 32'(stall_req), 32'd0);

    // Fill the FIFO behind a busy pipeline, then drain in order.
    for (int k = 1; k <= 4; k++) begin
      v = '0; v.iv = 1'b1; v.ia = 5'(k);
      step(v, "s3.iss");
    end
    for (int c = 0; c < 6; c++) begin
      v = '0; v.pw = 1'b1; v.pa = 5'd10; v.pd = 32'(c);
      if (c < 4) begin
        v.lv = 1'b1; v.la = 5'(c + 1); v.ld = 32'hC0DE0000 + 32'(c);
      end
      step(v, "s3.fill");
      if (c == 3) begin
        check("s3.lu_ready_full", 32'(lu_ready), 32'd0);
        check("s3.stall_full", 32'(stall_req), 32'd1);
      end
    end
    for (int k = 0; k < 4; k++) begin
      v = '0;
      step(v, "s3.drain");
      check("s3.drain_waddr", 32'(waddr), 32'(k + 1));
      check("s3.drain_wdata", wdata, 32'hC0DE0000 + 32'(k));
    end
    v = '0;
    step(v, "s3.empty");
    check("s3.empty_we", 32'(we), 32'd0);

    // Push and pop together at count 2, walking the pointers across the wrap.
    for (int k = 11; k <= 16; k++) begin
      v = '0; v.iv = 1'b1; v.ia = 5'(k);
      step(v, "s4.iss");
    end
    for (int k = 0; k < 2; k++) begin
      v = '0; v.pw = 1'b1; v.pa = 5'd20; v.pd = 32'h20;
      v.lv = 1'b1; v.la = 5'(11 + k); v.ld = 32'hB000 + 32'(k);
      step(v, "s4.prime");
    end
    for (int k = 0; k < 4; k++) begin
      v = '0; v.lv = 1'b1; v.la = 5'(13 + k); v.ld = 32'hB002 + 32'(k);
      step(v, "s4.pp");
      check("s4.pp_waddr", 32'(waddr), 32'(11 + k));
      check("s4.pp_lu_ready", 32'(lu_ready), 32'd1);
    end
    for (int k = 0; k < 2; k++) begin
      v = '0;
      step(v, "s4.drain");
      check("s4.drain_waddr", 32'(waddr), 32'(15 + k));
    end
    v = '0;
    step(v, "s4.empty");
    check("s4.empty_we", 32'(we), 32'd0);

    // Asynchronous reset with three queued results and r7/r11 pending.
    v = '0; v.iv = 1'b1; v.ia = 5'd7;  step(v, "s5.iss");
    v = '0; v.iv = 1'b1; v.ia = 5'd11; step(v, "s5.iss");
    for (int k = 0; k < 3; k++) begin
      v = '0; v.pw = 1'b1; v.pa = 5'd20; v.pd = 32'h55;
      v.lv = 1'b1; v.la = (k == 1) ? 5'd11 : 5'd7; v.ld = 32'hF00 + 32'(k);
      step(v, "s5.fill");
    end
    check("s5.busy_pre", busy, 32'h00000880);
    v = '0; v.e1 = 1'b1; v.a1 = 5'd7;
    drive(v);
    do_reset("s5.rst");
    for (int k = 0; k < 2; k++) begin
      v = '0;
      step(v, "s5.post");
      check("s5.post_we", 32'(we), 32'd0);
    end

    // Random traffic with legal long-op protocol.
    for (int c = 0; c < 400; c++) begin
      v = '0;
      v.pw = 1'($urandom_range(0, 1));
      v.pa = 5'($urandom);
      v.pd = $urandom;
      v.ia = 5'($urandom_range(1, 31));
      v.iv = ($urandom_range(0, 3) == 0) && !m_busy[v.ia];
      if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        v.lv = 1'b1; v.la = pend[0]; v.ld = $urandom;
      end
      v.e1 = 1'($urandom); v.a1 = 5'($urandom);
      v.e2 = 1'($urandom); v.a2 = 5'($urandom);
      rdy = (m_q.size() < DEPTH);
      step(v, "rnd");
      if (v.lv && rdy) void'(pend.pop_front());
      if (v.iv) pend.push_back(v.ia);
    end
    for (int k = 0; k < 8; k++) begin
      v = '0;
      step(v, "rnd.flush");
    end
    check("rnd.err_clean", 32'(err), 32'd0);

    // Protocol violations: double issue, unissued result, set-wins and r0 entry.
    v = '0; v.iv = 1'b1; v.ia = 5'd9; step(v, "s6.iss1");
    check("s6.err_after_first", 32'(err), 32'd0);
    v = '0; v.iv = 1'b1; v.ia = 5'd9; step(v, "s6.iss2");
    check("s6.err_double", 32'(err), 32'd1);
    check("s6.busy9", 32'(busy[9]), 32'd1);
    v = '0; v.lv = 1'b1; v.la = 5'd3; v.ld = 32'h33; step(v, "s6.lu3");
    v = '0; step(v, "s6.wr3");
    check("s6.wr3_we", 32'(we), 32'd1);
    check("s6.wr3_waddr", 32'(waddr), 32'd3);
    v = '0; v.pw = 1'b1; v.pa = 5'd2; v.pd = 32'h2;
    v.lv = 1'b1; v.la = 5'd9; v.ld = 32'h99; step(v, "s6.lu9");
    v = '0; v.iv = 1'b1; v.ia = 5'd9; step(v, "s6.setwin");
    check("s6.setwin_waddr", 32'(waddr), 32'd9);
    check("s6.setwin_busy9", 32'(busy[9]), 32'd1);
    v = '0; v.lv = 1'b1; v.la = 5'd0; v.ld = 32'h77; step(v, "s6.lu0");
    v = '0; step(v, "s6.pop0");
    check("s6.pop0_we", 32'(we), 32'd0);
    for (int k = 0; k < 3; k++) begin
      v = '0;
      step(v, "s6.hold");
      check("s6.err_sticky", 32'(err), 32'd1);
    end
    do_reset("s6.rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
